fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the buffer depth in 32-bit entries (power of two, at least 4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 SHALL have port mem_req, output, 1 bit, instruction-memory read request.
REQ-006 SHALL have port mem_addr, output, 32 bits, word-aligned read address.
REQ-007 SHALL have port mem_ack, input, 1 bit, read-data-valid strobe.
REQ-008 SHALL have port mem_rdata, input, 32 bits, read data, valid when mem_ack=1.
REQ-009 SHALL have port consume, input, 2 bits, number of instructions the scheduler takes this cycle (0, 1 or 2).
REQ-010 SHALL have port freeze, input, 1 bit; when high, nothing is consumed.
REQ-011 SHALL have port redirect, input, 1 bit, flush the buffer and restart fetch.
REQ-012 SHALL have port redirect_pc, input, 32 bits, new fetch address, sampled when redirect=1.
REQ-013 SHALL have ports instr0/instr1, output, 32 bits each, oldest and second-oldest buffered words.
REQ-014 SHALL have ports valid0/valid1, output, 1 bit each, set when the matching instr output holds a real entry.
REQ-015 SHALL have port pc0, output, 32 bits, address of instr0.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1) bits, occupied entries.
REQ-017 SHALL have port empty, output, 1 bit, equal to (count==0).

Function
REQ-018 SHALL implement a circular FIFO with head/tail pointers wrapping modulo DEPTH; occupancy is tracked by count, never by zero data.
REQ-019 SHALL set valid0=(count>=1) and valid1=(count>=2); when an instr output is invalid, it SHALL read 32'd0.
REQ-020 SHALL compute take = freeze ? 0 : min(consume, count); consume=3 SHALL be treated as 2.
REQ-021 SHALL each cycle advance head by take and pc0 by 4*take.
REQ-022 SHALL, in the same cycle, write mem_rdata at tail on an accepted ack, with count_next = count - take + ack_write.
REQ-023 SHALL use fetch FSM states IDLE, REQ and DROP.
REQ-024 IDLE: SHALL hold mem_req=0 and go to REQ when count_next < DEPTH.
REQ-025 REQ: SHALL hold mem_req=1 and mem_addr=fetch_pc stable until mem_ack.
REQ-026 REQ: on mem_ack, SHALL write the word, advance fetch_pc by 4, stay in REQ if count_next < DEPTH, and otherwise go to IDLE.
REQ-027 SHALL allow at most one outstanding request.
REQ-028 DROP: SHALL hold mem_req=1 and mem_addr at the stale address; on mem_ack, SHALL discard the data without writing it and go to REQ.
REQ-029 SHALL, on redirect, set count=0, head=tail, fetch_pc=redirect_pc and pc0=redirect_pc.
REQ-030 SHALL, on redirect, go to DROP if in REQ without mem_ack that cycle, and otherwise go to REQ.
REQ-031 SHALL give redirect priority over consume and ack; an ack coinciding with redirect SHALL be discarded.
REQ-032 SHALL, with full buffer, take=2 and mem_ack in the same cycle, accept the write: net count change -1, no overflow.
REQ-033 SHALL, with empty buffer and mem_ack in the same cycle, show the word on instr0/valid0 the following cycle; consume during an empty cycle SHALL have no effect.
REQ-034 SHALL keep fetch_pc and pc0 32-bit, wrapping modulo 2^32, and force mem_addr[1:0]=0.

Reset
REQ-035 SHALL, while rst=1, force count=0, head=tail=0, state=IDLE, mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, pc0=RESET_PC, valid0=valid1=0, instr0=instr1=0, empty=1.
REQ-036 SHALL, on rst asserted mid-transaction, abandon the pending request; a later mem_ack SHALL be ignored until a new request is issued.
REQ-037 SHALL enter REQ on the first clk edge after rst deasserts.

Verification
REQ-038 Fill: DEPTH=4, mem latency 3 and mem[i]=0xA000_0000+i, consume=0 -> count reaches 4, mem_req drops, instr0=0xA000_0000, instr1=0xA000_0001, pc0=0.
REQ-039 Dual issue: full buffer with consume=2 for one cycle -> instr0=0xA000_0002, pc0=8, count=2, and refetch from 0x10 starts.
REQ-040 Single slide: consume=1 -> instr0 becomes the previous instr1 and pc0 increases by 4; freeze=1 with consume=2 -> no change.
REQ-041 Redirect with request outstanding to redirect_pc=0x100 -> count=0 next cycle, stale ack discarded, first write is mem[0x40], pc0=0x100.
REQ-042 Wrap: 20 words streamed with random consume/freeze -> in-order delivery with no loss or duplicates across pointer wrap, and count never above 4.
REQ-043 Underflow: count=1 with consume=2 -> one entry removed, count=0, empty=1, valid0=0.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Bus bundle for fetch_buffer: instruction-memory read port, scheduler
// consume/redirect controls and the two-wide issue window.
//
// Memory handshake: the buffer raises mem_req with a word-aligned mem_addr and
// holds both stable until the cycle mem_ack=1 (mem_rdata valid in that cycle).
// Only one request is ever outstanding.
interface fetch_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [1:0]       consume;
    logic             freeze;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      instr0;
    logic [31:0]      instr1;
    logic             valid0;
    logic             valid1;
    logic [31:0]      pc0;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic [1:0]       dbg_state;

    modport master (
        output mem_req, mem_addr, instr0, instr1, valid0, valid1, pc0, count, empty, dbg_state,
        input  mem_ack, mem_rdata, consume, freeze, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr0, instr1, valid0, valid1, pc0, count, empty, dbg_state,
        output mem_ack, mem_rdata, consume, freeze, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of fetched words with a one-request
// fetch FSM, two-wide issue window, and flush-and-restart on redirect.
module fetch_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [31:0]      buf_q [DEPTH];
    logic [31:0]      buf_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nx;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pc0_q, pc0_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic [31:0]      addr_sel;
    logic [1:0]       consume_sat;
    logic [1:0]       take;
    logic             ack_write;

    always_comb begin
        consume_sat = (bus.consume == 2'd3) ? 2'd2 : bus.consume;
        take        = 2'd0;
        if (!bus.freeze) begin
            take = (CNT_W'(consume_sat) > count_q) ? count_q[1:0] : consume_sat;
        end
        // Only a live request in REQ may land; DROP responses and acks racing a redirect are discarded.
        ack_write = (state_q == REQ) && bus.mem_ack && !bus.redirect;
    end

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        pc0_d       = pc0_q;
        drop_addr_d = drop_addr_q;
        buf_d       = buf_q;

        if (bus.redirect) begin
            count_d     = '0;
            head_d      = tail_q;
            fetch_pc_d  = bus.redirect_pc;
            pc0_d       = bus.redirect_pc;
            // Keep presenting the in-flight address until its response drains.
            drop_addr_d = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
            state_d     = ((state_q != IDLE) && !bus.mem_ack) ? DROP : REQ;
        end else begin
            head_d  = head_q + PTR_W'(take);
            pc0_d   = pc0_q + {28'b0, take, 2'b00};
            count_d = count_q - CNT_W'(take) + CNT_W'(ack_write);
            if (ack_write) begin
                buf_d[tail_q] = bus.mem_rdata;
                tail_d        = tail_q + PTR_W'(1);
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            case (state_q)
                IDLE:    if (count_d < DEPTH_C) state_d = REQ;
                REQ:     if (bus.mem_ack) state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                DROP:    if (bus.mem_ack) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fetch_pc_q  <= RESET_PC;
            pc0_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            pc0_q       <= pc0_d;
            drop_addr_q <= drop_addr_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        head_nx  = head_q + PTR_W'(1);
        addr_sel = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    end

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_addr  = {addr_sel[31:2], 2'b00};
    assign bus.valid0    = (count_q >= CNT_W'(1));
    assign bus.valid1    = (count_q >= CNT_W'(2));
    assign bus.instr0    = bus.valid0 ? buf_q[head_q] : 32'd0;
    assign bus.instr1    = bus.valid1 ? buf_q[head_nx] : 32'd0;
    assign bus.pc0       = pc0_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer (DEPTH=4): latency-3 memory responder, queue-based
// reference model checked every cycle, plus directed literal expectations.
module tb_fetch_buffer;
    localparam int          DEPTH = 4;
    localparam int          LAT   = 3;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    bit          busy = 0;
    int          lat  = 0;
    logic [31:0] addr_l = '0;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            tick();
            bus.mem_ack = 1'b0;
            if (rst) begin
                busy = 0;
            end else if (busy) begin
                chk("req_held", {31'b0, bus.mem_req}, 32'd1);
                chk("addr_stable", bus.mem_addr, addr_l);
                lat++;
                if (lat == LAT) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = word_at(addr_l);
                    busy          = 0;
                end
            end else if (bus.mem_req) begin
                busy   = 1;
                lat    = 1;
                addr_l = bus.mem_addr;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] m_pc0    = RPC;
    logic [31:0] m_fetch  = RPC;
    bit          m_drop   = 0;
    int          popped   = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_pc0   = RPC;
                m_fetch = RPC;
                m_drop  = 0;
            end else if (bus.redirect) begin
                exp_q.delete();
                m_pc0   = bus.redirect_pc;
                m_fetch = bus.redirect_pc;
                m_drop  = busy && !bus.mem_ack;
            end else begin
                int c;
                int t;
                c = (bus.consume == 2'd3) ? 2 : int'(bus.consume);
                t = bus.freeze ? 0 : ((c < exp_q.size()) ? c : exp_q.size());
                for (int i = 0; i < t; i++) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
                m_pc0 = m_pc0 + 32'(4 * t);
                if (bus.mem_ack) begin
                    if (m_drop) begin
                        m_drop = 0;
                    end else begin
                        exp_q.push_back(word_at(m_fetch));
                        m_fetch = m_fetch + 32'd4;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        int n;
        n = exp_q.size();
        chk("valid0", {31'b0, bus.valid0}, {31'b0, n >= 1});
        chk("valid1", {31'b0, bus.valid1}, {31'b0, n >= 2});
        chk("instr0", bus.instr0, (n >= 1) ? exp_q[0] : 32'd0);
        chk("instr1", bus.instr1, (n >= 2) ? exp_q[1] : 32'd0);
        chk("pc0", bus.pc0, m_pc0);
        chk("count", 32'(bus.count), 32'(n));
        chk("empty", {31'b0, bus.empty}, {31'b0, n == 0});
        chk("count_le_depth", {31'b0, bus.count <= 3'(DEPTH)}, 32'd1);
        chk("addr_align", {30'b0, bus.mem_addr[1:0]}, 32'd0);
        if (rst) chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    end

    task automatic wait_count(input string name, input bit nonzero, input int val, input int budget);
        int n;
        n = 0;
        while (((nonzero && bus.count == 0) || (!nonzero && 32'(bus.count) != 32'(val))) && n < budget) begin
            tick();
            n++;
        end
        chk(name, {31'b0, n < budget}, 32'd1);
    endtask

    task automatic stream(input int words, input int budget);
        int start;
        int n;
        start = popped;
        n     = 0;
        while (popped - start < words && n < budget) begin
            bus.consume = 2'($urandom_range(0, 3));
            bus.freeze  = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        bus.consume = 2'd0;
        bus.freeze  = 1'b0;
        chk("stream_progress", {31'b0, popped - start >= words}, 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst             = 1'b1;
        bus.consume     = 2'd0;
        bus.freeze      = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", {31'b0, bus.mem_req}, 32'd0);
        chk("reset_addr", bus.mem_addr, 32'h0);
        chk("reset_empty", {31'b0, bus.empty}, 32'd1);
        rst = 1'b0;
        tick();
        chk("first_req", {31'b0, bus.mem_req}, 32'd1);

        // fill
        wait_count("fill_timeout", 0, 4, 60);
        tick();
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_req_off", {31'b0, bus.mem_req}, 32'd0);
        chk("fill_instr0", bus.instr0, 32'hA000_0000);
        chk("fill_instr1", bus.instr1, 32'hA000_0001);
        chk("fill_pc0", bus.pc0, 32'h0);

        // dual issue
        bus.consume = 2'd2;
        tick();
        bus.consume = 2'd0;
        chk("dual_instr0", bus.instr0, 32'hA000_0002);
        chk("dual_pc0", bus.pc0, 32'h8);
        chk("dual_count", 32'(bus.count), 32'd2);
        chk("dual_refetch_req", {31'b0, bus.mem_req}, 32'd1);
        chk("dual_refetch_addr", bus.mem_addr, 32'h10);

        // single slide and freeze
        wait_count("refill_timeout", 0, 4, 60);
        bus.consume = 2'd1;
        tick();
        bus.consume = 2'd0;
        chk("slide_instr0", bus.instr0, 32'hA000_0003);
        chk("slide_pc0", bus.pc0, 32'hC);
        bus.freeze  = 1'b1;
        bus.consume = 2'd2;
        tick();
        bus.freeze  = 1'b0;
        bus.consume = 2'd0;
        chk("freeze_instr0", bus.instr0, 32'hA000_0003);
        chk("freeze_pc0", bus.pc0, 32'hC);

        // redirect with a request outstanding
        wait_count("refill2_timeout", 0, 4, 60);
        bus.consume = 2'd1;
        tick();
        bus.consume     = 2'd0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("redir_pc0", bus.pc0, 32'h100);
        chk("redir_stale_addr", bus.mem_addr, 32'h1C);
        wait_count("redir_timeout", 1, 0, 40);
        chk("redir_first_word", bus.instr0, 32'hA000_0040);
        chk("redir_first_pc0", bus.pc0, 32'h100);
        chk("redir_first_count", 32'(bus.count), 32'd1);

        // underflow
        bus.consume = 2'd2;
        tick();
        bus.consume = 2'd0;
        chk("under_count", 32'(bus.count), 32'd0);
        chk("under_empty", {31'b0, bus.empty}, 32'd1);
        chk("under_valid0", {31'b0, bus.valid0}, 32'd0);

        // streaming across pointer wrap
        stream(20, 400);

        // 32-bit pc wraparound
        wait_count("drain_idle", 0, 4, 60);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect = 1'b0;
        wait_count("wrap_timeout", 1, 0, 40);
        chk("wrap_first_word", bus.instr0, 32'hDFFF_FFFE);
        chk("wrap_first_pc0", bus.pc0, 32'hFFFF_FFF8);
        stream(8, 200);

        // reset while a request is in flight
        wait_count("pre_rst_full", 0, 4, 60);
        bus.consume = 2'd1;
        tick();
        bus.consume = 2'd0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_count("post_rst_fill", 0, 4, 60);
        chk("post_rst_instr0", bus.instr0, 32'hA000_0000);
        chk("post_rst_pc0", bus.pc0, 32'h0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
